two_phase_sync_fifo: RTL and testbench
======================================

Name: two_phase_sync_fifo

Overview:
- Clocked, parametrised successor to the MouseTrap pipeline stage.
- Buffers up to DEPTH words between two asynchronous two-phase (transition-signalled) bundled-data channels inside one clock domain.
- Each incoming req and ack is synchronised before use.
- Sits at the boundary where an asynchronous MouseTrap pipeline meets clocked logic, or between two such pipelines that need elastic buffering and occupancy visibility.

Parameters:
- WORD_WIDTH, 32, data word width in bits.
- DEPTH, 4, buffer entries; power of two, 2..256.
- SYNC_STAGES, 2, flops in each req_in and ack_out synchroniser; allowed range 2..4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req_in  input  1  upstream request; each toggle offers one word.
- Data_in  input  WORD_WIDTH  upstream bundled data; stable from the req_in toggle until the matching ack_in toggle.
- ack_in  output  1  upstream acknowledge; toggles once per accepted word.
- req_out  output  1  downstream request; toggles once per launched word.
- Data_out  output  WORD_WIDTH  downstream bundled data; registered, stable while a launch is outstanding.
- ack_out  input  1  downstream acknowledge; each toggle completes one launch.
- count  output  $clog2(DEPTH+1)  words held in the buffer, excluding the word in flight on Data_out.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (async assert, synchronous-free release) clears:
  - both synchroniser chains, req_in_last, ack_in, req_out, Data_out, write/read pointers and count, all to 0;
  - resulting flags: empty=1, full=0.
- Reset mid-operation discards all buffered and in-flight words. Both channels restart at phase 0, so the upstream and downstream environments must be reset together.
- Input synchroniser: req_in passes through SYNC_STAGES flops, giving req_sync. A pending token exists when req_sync != req_in_last.
- Accept (rising edge):
  - Condition: pending token and full==0, evaluated on values registered before the edge.
  - Actions: mem[wr_ptr] <= Data_in; wr_ptr increments modulo DEPTH; req_in_last <= req_sync; ack_in <= req_sync.
- Pending while full:
  - ack_in is held and Data_in is not sampled.
  - The token is accepted on the first edge where full==0.
  - There is no same-edge pass-through when full.
- Output synchroniser: ack_out passes through SYNC_STAGES flops, giving ack_sync. The channel is idle when ack_sync == req_out.
- Launch (rising edge):
  - Condition: channel idle and empty==0.
  - Actions: Data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; req_out toggles.
  - At most one word is in flight at a time.
- Count update:
  - accept only: +1;
  - launch only: -1;
  - accept and launch on the same edge: unchanged, with both operations performed.
- Pointers wrap modulo DEPTH, so full and empty are derived from count, not from pointer equality.
- Latency, with req_in toggling before edge E1:
  - req_sync is valid after SYNC_STAGES edges.
  - Accept and the ack_in toggle occur at edge SYNC_STAGES+1.
  - If the buffer was empty and the output channel idle, the launch occurs at edge SYNC_STAGES+2.
- Ordering: words leave strictly in acceptance order.
- Data_out changes only at a launch edge or at reset.
- Throughput: a new req_in toggle made after ack_in toggles is accepted SYNC_STAGES+1 edges later. Streaming is therefore limited by the handshake round trip, not by the buffer.

Test Plan:
- Reset values: assert reset mid-clock with no clk edge -> ack_in=0, req_out=0, Data_out=0, count=0, empty=1, full=0 immediately.
- Single token (SYNC_STAGES=2): drive Data_in=32'hA5A5_0001 and toggle req_in before E1 -> ack_in toggles at E3, count=1 after E3; req_out toggles at E4 with Data_out=32'hA5A5_0001, count=0.
- Fill to full (DEPTH=4), with ack_out never toggled:
  - send words 1..5 -> the first word is in flight, words 2..5 are buffered, count=4, full=1;
  - a 6th req_in toggle leaves ack_in unchanged;
  - toggling ack_out once -> word 2 launches; the 6th word is accepted on the next edge and count returns to 4.
- Ordering and wrap: stream 3*DEPTH words 0..11 with immediate downstream acks -> Data_out sequence is 0..11 with no gaps or duplicates, and pointers wrap at least twice.
- Simultaneous accept and launch: with count=2 and output idle, present a pending token at the same edge -> count stays 2, the head word is launched and the new word is stored at the tail.
- Reset mid-operation: with count=3 and one word in flight, pulse reset -> all outputs return to their reset values; after release a fresh token from phase 0 is accepted normally.

Source files
------------

// File: rtl/two_phase_sync_fifo.sv
// Elastic FIFO between two transition-signalled bundled-data channels in one clock domain.
// Incoming req_in and ack_out are synchronised; accept and launch are each one word per edge.

module two_phase_sync_fifo_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset)
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};

  assign q = chain[STAGES-1];
endmodule

module two_phase_sync_fifo #(
  parameter int WORD_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_in,
  input  logic [WORD_WIDTH-1:0]      Data_in,
  output logic                       ack_in,
  output logic                       req_out,
  output logic [WORD_WIDTH-1:0]      Data_out,
  input  logic                       ack_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WORD_WIDTH-1:0] mem;
  logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
  logic                             req_sync, ack_sync, req_in_last;
  logic                             accept, launch;

  two_phase_sync_fifo_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk(clk), .reset(reset), .d(req_in),  .q(req_sync));
  two_phase_sync_fifo_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk(clk), .reset(reset), .d(ack_out), .q(ack_sync));

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  // Both decisions use pre-edge count, so a full buffer never passes a word straight through.
  assign accept = (req_sync != req_in_last) && !full;
  assign launch = (ack_sync == req_out) && !empty;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr] <= Data_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_in_last <= 1'b0;
      ack_in      <= 1'b0;
      req_out     <= 1'b0;
      Data_out    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      if (accept) begin
        wr_ptr      <= wr_ptr + PTR_W'(1);
        req_in_last <= req_sync;
        ack_in      <= req_sync;
      end
      if (launch) begin
        Data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_W'(1);
        req_out  <= ~req_out;
      end
      unique case ({accept, launch})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_two_phase_sync_fifo.sv
// Bench for two_phase_sync_fifo: directed tables/sequences plus random traffic against a queue model.

module tb_two_phase_sync_fifo;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int S  = 2;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          reset, req_in, ack_out;
  logic [W-1:0]  Data_in;
  logic          ack_in, req_out, full, empty;
  logic [W-1:0]  Data_out;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  two_phase_sync_fifo #(.WORD_WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .Data_in(Data_in), .ack_in(ack_in),
    .req_out(req_out), .Data_out(Data_out), .ack_out(ack_out), .count(count),
    .full(full), .empty(empty));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Token-level model: a queue of buffered words, one in-flight slot, and S-edge delayed views
  // of the two incoming phase wires.
  logic [W-1:0] mq[$];
  logic         m_req_last, m_ack_in, m_req_out;
  logic [W-1:0] m_dout;
  logic         rh[$], ah[$];

  task automatic m_reset();
    mq.delete(); rh.delete(); ah.delete();
    m_req_last = 0; m_ack_in = 0; m_req_out = 0; m_dout = '0;
    for (int i = 0; i < S; i++) begin rh.push_back(1'b0); ah.push_back(1'b0); end
  endtask

  task automatic cyc();
    logic rs, as_;
    bit   acc, lau;
    @(posedge clk);
    rs  = rh[0];
    as_ = ah[0];
    acc = (rs != m_req_last) && (mq.size() < D);
    lau = (as_ == m_req_out) && (mq.size() > 0);
    if (lau) begin m_dout = mq.pop_front(); m_req_out = ~m_req_out; end
    if (acc) begin mq.push_back(Data_in); m_req_last = rs; m_ack_in = rs; end
    void'(rh.pop_front()); rh.push_back(req_in);
    void'(ah.pop_front()); ah.push_back(ack_out);
    #1;
    check("model", {ack_in, req_out, full, empty, count, Data_out},
          {m_ack_in, m_req_out, mq.size() == D, mq.size() == 0, CW'(mq.size()), m_dout});
  endtask

  task automatic send_word(input logic [W-1:0] d);
    int n = 0;
    req_in  = ~req_in;
    Data_in = d;
    while (ack_in !== req_in && n < 50) begin cyc(); n++; end
    check("send_ack", ack_in, req_in);
  endtask

  logic [W-1:0] rx[$];
  logic         prev_rout;

  // Downstream acks every launch immediately; optionally records launched words.
  task automatic run(input int n, input bit rec);
    for (int i = 0; i < n; i++) begin
      if (req_out != ack_out) ack_out = ~ack_out;
      prev_rout = req_out;
      cyc();
      if (rec && req_out != prev_rout) rx.push_back(Data_out);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ack_in"},   ack_in,   0);
    check({tag, "_req_out"},  req_out,  0);
    check({tag, "_data_out"}, Data_out, 0);
    check({tag, "_count"},    count,    0);
    check({tag, "_empty"},    empty,    1);
    check({tag, "_full"},     full,     0);
  endtask

  typedef struct {
    logic          req;
    logic          ack;
    logic [W-1:0]  din;
    logic          e_ack;
    logic          e_rout;
    logic [CW-1:0] e_cnt;
    logic [W-1:0]  e_dout;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1, 0, 32'hA5A5_0001, 0, 0, 0, 32'h0};
    tbl[1] = '{1, 0, 32'hA5A5_0001, 0, 0, 0, 32'h0};
    tbl[2] = '{1, 0, 32'hA5A5_0001, 1, 0, 1, 32'h0};
    tbl[3] = '{1, 0, 32'hA5A5_0001, 1, 1, 0, 32'hA5A5_0001};
    tbl[4] = '{1, 1, 32'hA5A5_0001, 1, 1, 0, 32'hA5A5_0001};
    tbl[5] = '{1, 1, 32'hA5A5_0001, 1, 1, 0, 32'hA5A5_0001};

    reset = 0; req_in = 0; ack_out = 0; Data_in = '0;
    #2 reset = 1;
    #1 check_reset_outs("rst_async");
    @(posedge clk); @(posedge clk); #1 reset = 0;
    m_reset();

    // Single token latency
    for (int i = 0; i < 6; i++) begin
      req_in = tbl[i].req; ack_out = tbl[i].ack; Data_in = tbl[i].din;
      cyc();
      check($sformatf("tok%0d_ack_in", i),   ack_in,   tbl[i].e_ack);
      check($sformatf("tok%0d_req_out", i),  req_out,  tbl[i].e_rout);
      check($sformatf("tok%0d_count", i),    count,    tbl[i].e_cnt);
      check($sformatf("tok%0d_data_out", i), Data_out, tbl[i].e_dout);
    end

    // Fill to full with downstream stalled
    for (int w = 1; w <= 5; w++) send_word(W'(w));
    check("fill_count", count, D);
    check("fill_full", full, 1);
    check("fill_inflight", Data_out, 1);
    begin
      logic old_phase;
      old_phase = req_in;
      req_in = ~req_in; Data_in = 6;
      repeat (5) cyc();
      check("full_hold_ack", ack_in, old_phase);
    end
    ack_out = ~ack_out;
    repeat (3) cyc();
    check("unfull_launch2", Data_out, 2);
    check("unfull_count3", count, 3);
    cyc();
    check("unfull_accept6", ack_in, req_in);
    check("unfull_count4", count, D);

    // Ordering and pointer wrap
    run(40, 0);
    check("drain_empty", empty, 1);
    rx.delete();
    begin
      int k = 0;
      for (int c = 0; c < 400 && rx.size() < 3*D; c++) begin
        if (ack_in == req_in && k < 3*D) begin req_in = ~req_in; Data_in = W'(k); k++; end
        run(1, 1);
      end
    end
    check("stream_len", rx.size(), 3*D);
    for (int i = 0; i < 3*D; i++) check($sformatf("stream_%0d", i), rx[i], i);

    // Simultaneous accept and launch
    run(20, 0);
    send_word(100); send_word(101); send_word(102);
    check("sim_pre_count", count, 2);
    req_in = ~req_in; Data_in = 103; ack_out = ~ack_out;
    repeat (2) cyc();
    check("sim_wait_count", count, 2);
    cyc();
    check("sim_count", count, 2);
    check("sim_head", Data_out, 101);
    check("sim_acked", ack_in, req_in);
    rx.delete();
    run(30, 1);
    check("sim_tail_len", rx.size(), 2);
    check("sim_tail0", rx[0], 102);
    check("sim_tail1", rx[1], 103);

    // Reset mid-operation
    run(10, 0);
    send_word(200); send_word(201); send_word(202); send_word(203);
    check("mid_count", count, 3);
    #3 reset = 1; req_in = 0; ack_out = 0; Data_in = '0;
    #1 check_reset_outs("rst_mid");
    @(posedge clk); #1 reset = 0;
    m_reset();
    send_word(32'hCAFE_0001);
    repeat (2) cyc();
    check("post_rst_data", Data_out, 32'hCAFE_0001);
    check("post_rst_req_out", req_out, 1);
    check("post_rst_count", count, 0);

    // Random traffic with varying downstream pace
    for (int c = 0; c < 1500; c++) begin
      if (ack_in == req_in && $urandom_range(0, 2) == 0) begin
        req_in = ~req_in; Data_in = $urandom;
      end
      if (req_out != ack_out && $urandom_range(0, (c % 400 < 200) ? 8 : 1) == 0)
        ack_out = ~ack_out;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
